if_fetch_unit: RTL and testbench

- Parametrised next-generation instruction-fetch stage.
- Owns the PC and issues requests to instruction memory over a grant/response handshake with in-order, variable-latency responses.
- Buffers returned instructions, each with its PC, in a small ordered queue and presents them to ID with valid/ready.
- Supports stall, and redirect from EX (branch/jal) that flushes wrong-path work.

---
 rtl/if_pkg.sv | 20 ++
 rtl/if_fetch_unit_if.sv | 30 +++
 rtl/fetch_queue.sv | 81 ++++++++
 rtl/if_fetch_unit.sv | 120 ++++++++++++
 tb/tb_if_fetch_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

    localparam int              XLEN_DEFAULT      = 32;
    localparam logic [31:0]     RESET_VEC_DEFAULT = 32'h0000_0000;
    localparam int              INST_BYTES        = 4;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] inst;
        logic                    filled;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface if_fetch_unit_if
    import if_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) ();

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [XLEN-1:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );

endinterface

// File: rtl/fetch_queue.sv
// Ordered ring of fetched instructions: entries are allocated at grant,
// filled in order as responses return, and popped at the head.
module fetch_queue
    import if_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int FQ_DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush_i,
    input  logic                             alloc_i,
    input  logic [XLEN-1:0]                  alloc_pc_i,
    input  logic                             fill_i,
    input  logic [XLEN-1:0]                  fill_inst_i,
    input  logic                             pop_i,
    output logic                             head_valid_o,
    output logic [XLEN-1:0]                  head_pc_o,
    output logic [XLEN-1:0]                  head_inst_o,
    output logic [$clog2(FQ_DEPTH+1)-1:0]    alloc_cnt_o,
    output logic [$clog2(FQ_DEPTH+1)-1:0]    unfilled_cnt_o
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = $clog2(FQ_DEPTH+1);

    logic [PW-1:0]       head_q, tail_q, fill_q;
    logic [CW-1:0]       cnt_q, unf_q;
    logic [FQ_DEPTH-1:0] valid_q, filled_q;
    logic [XLEN-1:0]     pc_q   [FQ_DEPTH];
    logic [XLEN-1:0]     inst_q [FQ_DEPTH];
    logic                fill_ok, pop_ok;

    // A stray response with nothing outstanding must not advance the fill pointer.
    assign fill_ok = fill_i && (unf_q != '0);
    assign head_valid_o = valid_q[head_q] & filled_q[head_q];
    assign pop_ok = pop_i && head_valid_o;

    assign head_pc_o      = pc_q[head_q];
    assign head_inst_o    = inst_q[head_q];
    assign alloc_cnt_o    = cnt_q;
    assign unfilled_cnt_o = unf_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head_q   <= '0;
            tail_q   <= '0;
            fill_q   <= '0;
            cnt_q    <= '0;
            unf_q    <= '0;
            valid_q  <= '0;
            filled_q <= '0;
        end else begin
            if (alloc_i) begin
                valid_q[tail_q]  <= 1'b1;
                filled_q[tail_q] <= 1'b0;
                tail_q           <= tail_q + PW'(1);
            end
            if (fill_ok) begin
                filled_q[fill_q] <= 1'b1;
                fill_q           <= fill_q + PW'(1);
            end
            if (pop_ok) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            cnt_q <= cnt_q + CW'(alloc_i) - CW'(pop_ok);
            unf_q <= unf_q + CW'(alloc_i) - CW'(fill_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_i) begin
            pc_q[tail_q] <= alloc_pc_i;
        end
        if (fill_ok) begin
            inst_q[fill_q] <= fill_inst_i;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, boot/run/drain FSM, wrong-path drop counter
// and request issue; returned instructions are buffered in fetch_queue.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEFAULT,
    parameter int              FQ_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    if_fetch_unit_if.master   imem,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [XLEN-1:0]   id_pc_o,
    output logic [XLEN-1:0]   id_inst_o
);

    localparam int            CW        = $clog2(FQ_DEPTH+1);
    localparam logic [CW:0]   DEPTH_LIM = (CW+1)'(FQ_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   alloc_cnt, unfilled_cnt;
    logic [CW:0]     inflight;
    logic            head_valid;
    logic [XLEN-1:0] head_pc, head_inst;
    logic            issue, grant, fill, pop, rvalid;

    assign rvalid   = imem.imem_rvalid_i;
    assign inflight = {1'b0, alloc_cnt} + {1'b0, drop_cnt_q};

    // Issue depends only on registered state plus stall/redirect; never on id_ready_i.
    assign issue = !rst && (state_q != S_BOOT) && !stall_i && !redirect_i
                   && (inflight < DEPTH_LIM);
    assign grant = issue && imem.imem_gnt_i;

    assign imem.imem_req_o  = issue;
    assign imem.imem_addr_o = pc_q;

    assign fill = rvalid && (drop_cnt_q == '0) && !redirect_i;
    assign pop  = id_valid_o && id_ready_i && !redirect_i;

    assign id_valid_o = !rst && head_valid;
    assign id_pc_o    = id_valid_o ? head_pc   : '0;
    assign id_inst_o  = id_valid_o ? head_inst : '0;

    fetch_queue #(
        .XLEN     (XLEN),
        .FQ_DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (redirect_i),
        .alloc_i        (grant),
        .alloc_pc_i     (pc_q),
        .fill_i         (fill),
        .fill_inst_i    (imem.imem_rdata_i),
        .pop_i          (pop),
        .head_valid_o   (head_valid),
        .head_pc_o      (head_pc),
        .head_inst_o    (head_inst),
        .alloc_cnt_o    (alloc_cnt),
        .unfilled_cnt_o (unfilled_cnt)
    );

    // Requests still in flight at a redirect become drops; a response landing
    // in the redirect cycle itself retires one of them immediately.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (redirect_i) begin
            drop_cnt_d = drop_cnt_q + unfilled_cnt - CW'(rvalid);
        end else if (rvalid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i & ~XLEN'(INST_BYTES - 1);
        end else if (grant) begin
            pc_d = pc_q + XLEN'(INST_BYTES);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (redirect_i && (drop_cnt_d != '0)) state_d = S_DRAIN;
            S_DRAIN: if (drop_cnt_d == '0) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_VEC;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(rvalid && (drop_cnt_q == '0) && (unfilled_cnt == '0)))
                else $error("if_fetch_unit: imem response with no outstanding request");
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a small in-order instruction memory.
module tb_if_fetch_unit;
    import if_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        resp_en;
    logic        gnt_seen;

    logic [31:0] pend[$];
    logic [31:0] gnt_log[$];
    logic [63:0] popped[$];

    int errors = 0;
    int checks = 0;

    if_fetch_unit_if #(.XLEN(32)) imem_bus ();

    if_fetch_unit #(
        .XLEN      (32),
        .RESET_VEC (32'h0000_0000),
        .FQ_DEPTH  (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem          (imem_bus),
        .id_valid_o    (id_valid),
        .id_ready_i    (id_ready),
        .id_pc_o       (id_pc),
        .id_inst_o     (id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory: in order, one cycle after grant when responses are enabled.
    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
            gnt_seen               <= 1'b0;
            imem_bus.imem_rvalid_i <= 1'b0;
            imem_bus.imem_rdata_i  <= '0;
        end else begin
            gnt_seen <= imem_bus.imem_req_o && imem_bus.imem_gnt_i;
            if (imem_bus.imem_req_o && imem_bus.imem_gnt_i) begin
                pend.push_back(imem_bus.imem_addr_o);
                gnt_log.push_back(imem_bus.imem_addr_o);
            end
            if (id_valid && id_ready) popped.push_back({id_pc, id_inst});
            if (resp_en && pend.size() != 0) begin
                imem_bus.imem_rvalid_i <= 1'b1;
                imem_bus.imem_rdata_i  <= mem_word(pend.pop_front());
            end else begin
                imem_bus.imem_rvalid_i <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    int gb, pb, sg;
    logic [31:0] last;

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        id_ready = 1'b1; resp_en = 1'b1; imem_bus.imem_gnt_i = 1'b1;
        #1;
        chk("rst_req",   32'(imem_bus.imem_req_o), 32'd0);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_pc",    id_pc,   32'h0);
        chk("rst_inst",  id_inst, 32'h0);
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("boot_req",   32'(imem_bus.imem_req_o), 32'd0);
        chk("boot_valid", 32'(id_valid), 32'd0);

        // Streaming with immediate grant and 1-cycle responses
        gb = gnt_log.size(); pb = popped.size();
        cyc();
        chk("t1_first_req",  32'(imem_bus.imem_req_o), 32'd1);
        chk("t1_first_addr", imem_bus.imem_addr_o, 32'h0);
        cyc(); cyc();
        chk("t1_lat_valid", 32'(id_valid), 32'd1);
        chk("t1_lat_pc",    id_pc, 32'h0);
        for (int i = 0; i < 20 && popped.size() < pb + 3; i++) cyc();
        chk("t1_npop", 32'(popped.size() >= pb + 3), 32'd1);
        chk("t1_pc0",   popped[pb][63:32],   32'h0000_0000);
        chk("t1_inst0", popped[pb][31:0],    32'hDEAD_0000);
        chk("t1_pc1",   popped[pb+1][63:32], 32'h0000_0004);
        chk("t1_inst1", popped[pb+1][31:0],  32'hDEAD_0004);
        chk("t1_pc2",   popped[pb+2][63:32], 32'h0000_0008);
        chk("t1_inst2", popped[pb+2][31:0],  32'hDEAD_0008);

        // ID back-pressure fills the queue and blocks issue
        id_ready = 1'b0;
        do_reset();
        gb = gnt_log.size();
        repeat (10) cyc();
        chk("t2_ngnt",  32'(gnt_log.size() - gb), 32'd2);
        chk("t2_gnt0",  gnt_log[gb],   32'h0);
        chk("t2_gnt1",  gnt_log[gb+1], 32'h4);
        chk("t2_req",   32'(imem_bus.imem_req_o), 32'd0);
        chk("t2_valid", 32'(id_valid), 32'd1);
        chk("t2_pc",    id_pc, 32'h0);
        id_ready = 1'b1;
        cyc();
        chk("t2_req_after_pop",  32'(imem_bus.imem_req_o), 32'd1);
        chk("t2_addr_after_pop", imem_bus.imem_addr_o, 32'h8);

        // Redirect with two unfilled requests in flight
        resp_en = 1'b0;
        do_reset();
        gb = gnt_log.size();
        for (int i = 0; i < 10 && gnt_log.size() < gb + 2; i++) cyc();
        chk("t3_ngnt", 32'(gnt_log.size() - gb), 32'd2);
        redirect = 1'b1; redirect_pc = 32'h0000_0103; resp_en = 1'b1;
        #1;
        chk("t3_req_redir", 32'(imem_bus.imem_req_o), 32'd0);
        cyc();
        redirect = 1'b0;
        pb = popped.size();
        #1;
        chk("t3_state", 32'(dut.state_q), 32'(S_DRAIN));
        chk("t3_drop",  32'(dut.drop_cnt_q), 32'd2);
        chk("t3_req_drain", 32'(imem_bus.imem_req_o), 32'd0);
        for (int i = 0; i < 20 && popped.size() < pb + 1; i++) cyc();
        chk("t3_npop",  32'(popped.size() >= pb + 1), 32'd1);
        chk("t3_pc",    popped[pb][63:32], 32'h0000_0100);
        chk("t3_inst",  popped[pb][31:0],  32'hDEAD_0100);
        chk("t3_gnt",   gnt_log[gb+2], 32'h0000_0100);
        chk("t3_state_end", 32'(dut.state_q), 32'(S_RUN));
        chk("t3_drop_end",  32'(dut.drop_cnt_q), 32'd0);

        // Redirect coinciding with the only outstanding response
        resp_en = 1'b0;
        do_reset();
        gb = gnt_log.size();
        for (int i = 0; i < 10 && gnt_log.size() < gb + 1; i++) cyc();
        imem_bus.imem_gnt_i = 1'b0;
        resp_en = 1'b1;
        cyc();
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        cyc();
        redirect = 1'b0; imem_bus.imem_gnt_i = 1'b1;
        pb = popped.size();
        #1;
        chk("t4_state", 32'(dut.state_q), 32'(S_RUN));
        chk("t4_drop",  32'(dut.drop_cnt_q), 32'd0);
        chk("t4_req",   32'(imem_bus.imem_req_o), 32'd1);
        chk("t4_addr",  imem_bus.imem_addr_o, 32'h0000_0200);
        for (int i = 0; i < 20 && popped.size() < pb + 1; i++) cyc();
        chk("t4_pc",   popped[pb][63:32], 32'h0000_0200);
        chk("t4_inst", popped[pb][31:0],  32'hDEAD_0200);

        // Stall right after a grant: issue frozen, the response still drains to ID
        for (int i = 0; i < 10 && !gnt_seen; i++) cyc();
        chk("t5_gnt_seen", 32'(gnt_seen), 32'd1);
        last = gnt_log[gnt_log.size()-1];
        sg = gnt_log.size();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_stall_req",  32'(imem_bus.imem_req_o), 32'd0);
            chk("t5_stall_addr", imem_bus.imem_addr_o, last + 32'd4);
            cyc();
        end
        stall = 1'b0;
        #1;
        chk("t5_nogrant", 32'(gnt_log.size()), 32'(sg));
        chk("t5_popped",  popped[popped.size()-1][63:32], last);
        chk("t5_req",     32'(imem_bus.imem_req_o), 32'd1);
        chk("t5_addr",    imem_bus.imem_addr_o, last + 32'd4);

        // PC wrap at the top of the address space, then reset with a full queue
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        cyc();
        redirect = 1'b0;
        gb = gnt_log.size(); pb = popped.size();
        for (int i = 0; i < 30 && (popped.size() < pb + 3 || gnt_log.size() < gb + 3); i++) cyc();
        chk("t6_gnt0",  gnt_log[gb],   32'hFFFF_FFF8);
        chk("t6_gnt1",  gnt_log[gb+1], 32'hFFFF_FFFC);
        chk("t6_gnt2",  gnt_log[gb+2], 32'h0000_0000);
        chk("t6_pc1",   popped[pb+1][63:32], 32'hFFFF_FFFC);
        chk("t6_inst1", popped[pb+1][31:0],  32'h2152_FFFC);
        chk("t6_pc2",   popped[pb+2][63:32], 32'h0000_0000);
        chk("t6_inst2", popped[pb+2][31:0],  32'hDEAD_0000);
        id_ready = 1'b0;
        repeat (8) cyc();
        chk("t6_full_valid", 32'(id_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(id_valid), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("t6_post_valid", 32'(id_valid), 32'd0);
        chk("t6_post_req",   32'(imem_bus.imem_req_o), 32'd0);
        chk("t6_post_pc",    dut.pc_q, 32'h0000_0000);
        chk("t6_post_state", 32'(dut.state_q), 32'(S_BOOT));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
